lsu_mem_access: RTL and testbench

Parametrised load/store unit that replaces the fixed 16-bit, zero-wait, combinational memory-access stage of the RISC-V pipeline.
- Accepts one request per transaction from execute over a valid/ready handshake.
- Drives a data-memory port with byte enables and variable-latency acknowledge.
- Aligns, sign- or zero-extends load data and returns one registered response to the write-back stage.
- Adds misaligned, illegal-size and timeout detection.

---
 rtl/lsu_mem_access_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 37 +++
 rtl/lsu_mem_access.sv | 135 +++++++++++++
 tb/tb_lsu_mem_access.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_access_pkg.sv
// lsu_mem_access_pkg: shared op/size/error/state encodings and the request legality check for the load/store unit
package lsu_mem_access_pkg;

    typedef enum logic [1:0] {
        LSU_OP_LOAD  = 2'b00,
        LSU_OP_STORE = 2'b01,
        LSU_OP_PASS  = 2'b10,
        LSU_OP_RSVD  = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        LSU_SZ_B = 2'b00,
        LSU_SZ_H = 2'b01,
        LSU_SZ_W = 2'b10,
        LSU_SZ_D = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_ERR_OK       = 2'b00,
        LSU_ERR_MISALIGN = 2'b01,
        LSU_ERR_TIMEOUT  = 2'b10,
        LSU_ERR_ILLEGAL  = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // (1 << size) - 1 wraps to 3'b111 for a double, giving the alignment mask for every size
    function automatic lsu_err_e lsu_check(input lsu_size_e size, input logic [2:0] lo, input logic is64);
        return (size == LSU_SZ_D && !is64) ? LSU_ERR_ILLEGAL :
               ((lo & ((3'd1 << size) - 3'd1)) != 3'd0) ? LSU_ERR_MISALIGN : LSU_ERR_OK;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte-enable/lane shift and load extract/sign-or-zero extend
module lsu_lane_align
    import lsu_mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsu_size_e                   size,
    input  logic                        uns,
    input  logic [$clog2(XLEN/8)-1:0]   lane,
    input  logic [XLEN-1:0]             wdata,
    input  logic [XLEN-1:0]             rdata,
    output logic [XLEN/8-1:0]           be,
    output logic [XLEN-1:0]             wdata_sh,
    output logic [XLEN-1:0]             rdata_ext
);
    localparam int NB = XLEN / 8;
    localparam int XW = $clog2(XLEN);

    logic [NB-1:0]   msk;
    logic [XLEN-1:0] repl, sh, lowm;
    logic [XW-1:0]   sidx;

    always_comb begin
        repl = size == LSU_SZ_B ? {NB{wdata[7:0]}} :
               size == LSU_SZ_H ? {(NB/2){wdata[15:0]}} :
               size == LSU_SZ_W ? {(NB/4){wdata[31:0]}} : wdata;
        msk  = (NB'(1) << (4'd1 << size)) - NB'(1);
        sh   = rdata >> {lane, 3'b000};
        lowm = ~({XLEN{1'b1}} << (7'd8 << size));
        sidx = XW'((7'd8 << size) - 7'd1);
    end

    assign be        = msk << lane;
    assign wdata_sh  = repl << {lane, 3'b000};
    assign rdata_ext = (sh & lowm) | ({XLEN{sh[sidx] & ~uns}} & ~lowm);

endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: valid/ready load/store unit with variable-latency memory port, alignment checks and timeout
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic                CK_REF,
    input  logic                RST_N,
    input  logic                HALT,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic [1:0]          REQ_OP,
    input  logic [1:0]          REQ_SIZE,
    input  logic                REQ_UNSIGNED,
    input  logic [XLEN-1:0]     REQ_ADDR,
    input  logic [XLEN-1:0]     REQ_WDATA,
    input  logic [4:0]          REQ_RD,
    output logic                RSP_VALID,
    output logic                RSP_WB,
    output logic [4:0]          RSP_RD,
    output logic [XLEN-1:0]     RSP_DATA,
    output logic [1:0]          RSP_ERR,
    output logic                MEM_REQ,
    output logic                MEM_READ_WRN,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic [XLEN/8-1:0]   MEM_BE,
    output logic [XLEN-1:0]     MEM_WDATA,
    input  logic [XLEN-1:0]     MEM_RDATA,
    input  logic                MEM_ACK
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic            int_rst_n;
    lsu_state_e      state, state_nxt;
    lsu_op_e         op_q;
    lsu_size_e       size_q;
    lsu_err_e        err_q, req_err;
    logic            uns_q, acc, mem_op, ack, tmo, rsp;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0] wdata_q, data_q, wsh, rext;
    logic [4:0]      rd_q;
    logic [CW-1:0]   cnt;
    logic [NB-1:0]   be;

    assign int_rst_n = RST_N;
    assign mem_op    = REQ_OP == LSU_OP_LOAD || REQ_OP == LSU_OP_STORE;
    assign req_err   = mem_op ? lsu_check(lsu_size_e'(REQ_SIZE), REQ_ADDR[2:0], XLEN == 64) : LSU_ERR_OK;
    assign acc       = state == ST_IDLE && REQ_VALID && !HALT;
    assign ack       = state == ST_ACCESS && MEM_ACK;
    // Timeout only advances on un-halted cycles; a same-cycle ACK always wins
    assign tmo       = state == ST_ACCESS && !MEM_ACK && !HALT && cnt == CW'(MAX_WAIT - 1);
    assign rsp       = state == ST_RESP;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .size      (size_q),
        .uns       (uns_q),
        .lane      (addr_q[LW-1:0]),
        .wdata     (wdata_q),
        .rdata     (MEM_RDATA),
        .be        (be),
        .wdata_sh  (wsh),
        .rdata_ext (rext)
    );

    always_ff @(posedge CK_REF or negedge int_rst_n) begin
        if (!int_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        REQ_READY = 1'b0;
        MEM_REQ   = 1'b0;
        RSP_VALID = 1'b0;
        case (state)
            ST_IDLE: begin
                REQ_READY = !HALT;
                if (acc) state_nxt = (req_err != LSU_ERR_OK || !mem_op) ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                MEM_REQ = 1'b1;
                if (ack || tmo) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                RSP_VALID = !HALT;
                if (!HALT) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign MEM_READ_WRN = !MEM_REQ || op_q == LSU_OP_LOAD;
    assign MEM_ADDR     = MEM_REQ ? {addr_q[ADDR_W-1:LW], {LW{1'b0}}} : '0;
    assign MEM_BE       = MEM_REQ ? be : '0;
    assign MEM_WDATA    = MEM_REQ ? wsh : '0;
    assign RSP_RD       = rsp ? rd_q : '0;
    assign RSP_DATA     = rsp ? data_q : '0;
    assign RSP_ERR      = rsp ? err_q : LSU_ERR_OK;
    assign RSP_WB       = RSP_VALID && err_q == LSU_ERR_OK && op_q != LSU_OP_STORE;

    always_ff @(posedge CK_REF or negedge int_rst_n) begin
        if (!int_rst_n) begin
            op_q    <= LSU_OP_LOAD;
            size_q  <= LSU_SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            err_q   <= LSU_ERR_OK;
            cnt     <= '0;
        end else if (acc) begin
            op_q    <= lsu_op_e'(REQ_OP);
            size_q  <= lsu_size_e'(REQ_SIZE);
            uns_q   <= REQ_UNSIGNED;
            addr_q  <= REQ_ADDR[ADDR_W-1:0];
            wdata_q <= REQ_WDATA;
            data_q  <= mem_op ? '0 : REQ_WDATA;
            rd_q    <= REQ_RD;
            err_q   <= req_err;
            cnt     <= '0;
        end else if (ack) begin
            data_q  <= op_q == LSU_OP_LOAD ? rext : '0;
        end else if (tmo) begin
            err_q   <= LSU_ERR_TIMEOUT;
        end else if (state == ST_ACCESS && !HALT) begin
            cnt     <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb_lsu_mem_access: directed vectors with hand-computed expectations for the load/store unit
module tb_lsu_mem_access;
    logic        clk = 0, rst_n = 0, halt = 0, req_valid = 0, req_unsigned = 0, mem_ack = 0;
    logic        req_ready, rsp_valid, rsp_wb, mem_req, mem_read_wrn;
    logic [1:0]  req_op = 0, req_size = 0, rsp_err;
    logic [31:0] req_addr = 0, req_wdata = 0, rsp_data, mem_wdata, mem_rdata = 0;
    logic [4:0]  req_rd = 0, rsp_rd;
    logic [15:0] mem_addr;
    logic [3:0]  mem_be;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    lsu_mem_access #(.XLEN(32), .ADDR_W(16), .MAX_WAIT(4)) dut (
        .CK_REF(clk), .RST_N(rst_n), .HALT(halt),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op), .REQ_SIZE(req_size),
        .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_RD(req_rd),
        .RSP_VALID(rsp_valid), .RSP_WB(rsp_wb), .RSP_RD(rsp_rd), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
        .MEM_REQ(mem_req), .MEM_READ_WRN(mem_read_wrn), .MEM_ADDR(mem_addr), .MEM_BE(mem_be),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        req_op = op; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d; req_rd = rd;
        req_valid = 1;
        chk("req_ready", req_ready, 1);
        step();
        req_valid = 0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                           input logic [31:0] rdat, input logic [31:0] exp, input logic [3:0] be);
        req(2'b00, sz, uns, a, 32'h0, 5'd1);
        chk("ld_mem_req", mem_req, 1);
        chk("ld_rwn", mem_read_wrn, 1);
        chk("ld_addr", mem_addr, {a[15:2], 2'b00});
        chk("ld_be", mem_be, be);
        mem_ack = 1; mem_rdata = rdat;
        step();
        mem_ack = 0;
        chk("ld_rsp_valid", rsp_valid, 1);
        chk("ld_rsp_data", rsp_data, exp);
        chk("ld_rsp_wb", rsp_wb, 1);
        chk("ld_rsp_rd", rsp_rd, 1);
        chk("ld_rsp_err", rsp_err, 0);
        chk("ld_mem_be_idle", mem_be, 0);
        step();
        chk("ld_rsp_done", rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_rwn", mem_read_wrn, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_be", mem_be, 0);
        rst_n = 1;
        step();

        do_load(32'h10, 2'b10, 0, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'b1111);
        do_load(32'h13, 2'b00, 0, 32'h8000_0000, 32'hFFFF_FF80, 4'b1000);
        do_load(32'h13, 2'b00, 1, 32'h8000_0000, 32'h0000_0080, 4'b1000);
        do_load(32'h02, 2'b01, 0, 32'h8001_0000, 32'hFFFF_8001, 4'b1100);

        req(2'b01, 2'b01, 0, 32'h6, 32'h1234_ABCD, 5'd3);
        for (int i = 0; i < 4; i++) begin
            chk("st_mem_req", mem_req, 1);
            chk("st_rwn", mem_read_wrn, 0);
            chk("st_be", mem_be, 4'b1100);
            chk("st_wdata", mem_wdata, 32'hABCD_0000);
            chk("st_addr", mem_addr, 16'h0004);
            chk("st_no_rsp", rsp_valid, 0);
            mem_ack = (i == 3);
            step();
        end
        mem_ack = 0;
        chk("st_rsp_valid", rsp_valid, 1);
        chk("st_rsp_wb", rsp_wb, 0);
        chk("st_rsp_err", rsp_err, 0);
        step();

        req(2'b00, 2'b10, 0, 32'h5, 32'h0, 5'd2);
        chk("mis_mem_req", mem_req, 0);
        chk("mis_rsp_valid", rsp_valid, 1);
        chk("mis_err", rsp_err, 2'b01);
        chk("mis_wb", rsp_wb, 0);
        chk("mis_data", rsp_data, 0);
        step();

        req(2'b00, 2'b11, 0, 32'h8, 32'h0, 5'd2);
        chk("ill_mem_req", mem_req, 0);
        chk("ill_err", rsp_err, 2'b11);
        chk("ill_wb", rsp_wb, 0);
        step();

        req(2'b10, 2'b10, 0, 32'h5, 32'h5A5A_1234, 5'd7);
        chk("pass_rsp_valid", rsp_valid, 1);
        chk("pass_data", rsp_data, 32'h5A5A_1234);
        chk("pass_wb", rsp_wb, 1);
        chk("pass_rd", rsp_rd, 7);
        chk("pass_err", rsp_err, 0);
        step();

        req(2'b00, 2'b10, 0, 32'h20, 32'h0, 5'd4);
        for (int i = 0; i < 4; i++) begin
            chk("tmo_mem_req", mem_req, 1);
            step();
        end
        chk("tmo_mem_req_drop", mem_req, 0);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_err", rsp_err, 2'b10);
        chk("tmo_wb", rsp_wb, 0);
        chk("tmo_data", rsp_data, 0);
        step();
        step();
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("late_ack_rsp", rsp_valid, 0);
        chk("late_ack_mem_req", mem_req, 0);
        chk("late_ack_ready", req_ready, 1);
        step();
        chk("late_ack_rsp2", rsp_valid, 0);

        req(2'b00, 2'b10, 0, 32'h30, 32'h0, 5'd9);
        halt = 1;
        for (int i = 0; i < 5; i++) begin
            chk("halt_mem_req", mem_req, 1);
            step();
        end
        mem_ack = 1; mem_rdata = 32'h1122_3344;
        step();
        mem_ack = 0;
        for (int i = 0; i < 2; i++) begin
            chk("halt_rsp_sup", rsp_valid, 0);
            chk("halt_mem_req_off", mem_req, 0);
            step();
        end
        halt = 0;
        #1;
        chk("halt_rsp_valid", rsp_valid, 1);
        chk("halt_rsp_data", rsp_data, 32'h1122_3344);
        step();
        chk("halt_rsp_single", rsp_valid, 0);
        halt = 1;
        #1;
        chk("halt_idle_ready", req_ready, 0);
        halt = 0;
        step();

        req(2'b00, 2'b10, 0, 32'h40, 32'h0, 5'd3);
        chk("rstm_mem_req", mem_req, 1);
        rst_n = 0;
        #1;
        chk("rstm_mem_req_off", mem_req, 0);
        chk("rstm_ready", req_ready, 1);
        chk("rstm_rwn", mem_read_wrn, 1);
        #2;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstm_no_rsp", rsp_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
